smart_counter_ctrl: RTL and testbench
=====================================

SMART_COUNTER_CTRL -- requirements
Module: smart_counter_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: counter/data width in bits.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid / req1_valid  input  1 each  requester N has a command pending.
REQ-005 req0_ready / req1_ready  output  1 each  command from requester N accepted this cycle when valid&ready.
REQ-006 req0_start / req1_start  input  WIDTH each  counter preload value.
REQ-007 req0_steps / req1_steps  input  WIDTH each  number of increments to perform.
REQ-008 cnt_load  output  1  synchronous load strobe to counter.
REQ-009 cnt_enable  output  1  increment enable to counter.
REQ-010 cnt_data  output  WIDTH  load value to counter.
REQ-011 cnt_value  input  WIDTH  current counter output.
REQ-012 done  output  1  one-cycle pulse at command completion.
REQ-013 done_id  output  1  requester that owned the completed command.
REQ-014 result  output  WIDTH  cnt_value sampled at completion, held until the next done.

Function
REQ-015 FSM states IDLE, LOAD, RUN, DONE; cnt_load, cnt_enable and done are exactly one-hot with LOAD, RUN and DONE respectively.
REQ-016 IDLE: reqN_ready is high only for the arbitration winner, only in IDLE; no ready in any other state.
REQ-017 Arbitration is round-robin: if one valid, grant it; if both valid, grant the requester not served last; after reset req0 has priority.
REQ-018 On accept (cycle 0) the controller latches start, steps and the requester id; state goes to LOAD.
REQ-019 LOAD (cycle 1): cnt_load=1, cnt_data=latched start; next state RUN if steps!=0, else DONE.
REQ-020 RUN: cnt_enable=1 for exactly steps consecutive cycles (cycles 2..1+steps); a remaining-steps down-counter decrements each RUN cycle, and the state moves to DONE on the cycle remaining==1.
REQ-021 DONE (cycle 2+steps): done=1, done_id=owner, result=cnt_value; next state IDLE; a new accept is possible no earlier than the following cycle.
REQ-022 cnt_data holds the last latched start outside LOAD; its value there is don't-care for the counter.
REQ-023 Counter wrap-around (start+steps > 2^WIDTH-1) is not an error; result = (start+steps) mod 2^WIDTH.
REQ-024 The controller ignores valid changes and input data changes after accept until it returns to IDLE.

Reset
REQ-025 rst_n low forces immediately, from any state: state IDLE, ready/cnt_load/cnt_enable/done=0, cnt_data/result/done_id=0, round-robin pointer=req0.
REQ-026 Reset during LOAD or RUN abandons the command with no done pulse; the first accept after release takes cycle 0 as in REQ-018.

Configuration
REQ-027 Macro SMART_COUNTER_CTRL_ABORT_EN defined: adds input abort (1 bit) and output done_aborted (1 bit).
REQ-028 With the macro, abort high in LOAD or RUN forces cnt_load=0 and cnt_enable=0 in that same cycle; the next state is DONE with done_aborted=1 and result=cnt_value; done_aborted=0 on normal completion; abort is ignored in IDLE and DONE.
REQ-029 Without the macro, both ports are absent and behaviour is exactly REQ-015..REQ-024.

Structure
REQ-030 Package smart_counter_ctrl_pkg holds the FSM state enum typedef and the default WIDTH constant.
REQ-031 Sub-module rr_arb2 implements the 2-way round-robin arbiter (inputs: valids, enable, pointer update; outputs: one-hot grant).

Verification
REQ-032 req0 start=8'h10 steps=5 with a behavioural counter model -> ready cycle 0, load cycle 1, enable cycles 2-6, done cycle 7, result=8'h15, done_id=0.
REQ-033 req1 start=8'hFE steps=4 -> result=8'h02 (wrap), done_id=1.
REQ-034 steps=0, start=8'h33 -> no enable, done cycle 2, result=8'h33.
REQ-035 Both valid continuously for four commands -> grant order 0,1,0,1; never two readies in one cycle.
REQ-036 rst_n low during RUN of steps=10 -> all outputs 0 within the same cycle, no done; the next command behaves as in REQ-032.
REQ-037 ABORT_EN: abort in the 3rd RUN cycle of start=0 steps=10 -> enable low in that cycle, done next cycle, result=2, done_aborted=1.

Source files
------------

// File: rtl/smart_counter_ctrl_pkg.sv
// Shared types and defaults for the smart counter controller.
package smart_counter_ctrl_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; after reset req0 wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       enable,
  input  logic       update,
  output logic [1:0] grant
);

  // High when requester 1 should win the next tie.
  logic prio_q;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (update) begin
      prio_q <= grant[0];
    end
  end

endmodule

// File: rtl/smart_counter_ctrl.sv
// Sequences load/increment of an external counter for two round-robin requesters.
// Optional abort input enabled by defining SMART_COUNTER_CTRL_ABORT_EN.
module smart_counter_ctrl
  import smart_counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_start,
  input  logic [WIDTH-1:0] req0_steps,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_start,
  input  logic [WIDTH-1:0] req1_steps,
  output logic             cnt_load,
  output logic             cnt_enable,
  output logic [WIDTH-1:0] cnt_data,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result
`ifdef SMART_COUNTER_CTRL_ABORT_EN
  ,
  input  logic             abort,
  output logic             done_aborted
`endif
);

  state_e           state_q;
  logic [WIDTH-1:0] start_q, rem_q, result_q;
  logic             owner_q, done_id_q;
  logic             load_q, enable_q, done_q;
  logic [1:0]       grant;
  logic             accept;
  logic             abort_hit;

`ifdef SMART_COUNTER_CTRL_ABORT_EN
  logic aborted_q;

  assign abort_hit = abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted_q <= 1'b0;
    end else if (state_q == StLoad || state_q == StRun) begin
      aborted_q <= abort;
    end
  end

  assign done_aborted = done_q & aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  // Ready is suppressed while reset is held so it reads zero immediately.
  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid ({req1_valid, req0_valid}),
    .enable(state_q == StIdle && rst_n),
    .update(accept),
    .grant (grant)
  );

  assign accept     = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign cnt_load   = load_q & ~abort_hit;
  assign cnt_enable = enable_q & ~abort_hit;
  assign cnt_data   = start_q;
  assign done       = done_q;
  assign done_id    = done_id_q;
  // The counter only settles on the completion cycle, so pass it through then.
  assign result     = done_q ? cnt_value : result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      start_q   <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      owner_q   <= 1'b0;
      done_id_q <= 1'b0;
      load_q    <= 1'b0;
      enable_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      load_q   <= 1'b0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            start_q <= grant[1] ? req1_start : req0_start;
            rem_q   <= grant[1] ? req1_steps : req0_steps;
            owner_q <= grant[1];
            state_q <= StLoad;
            load_q  <= 1'b1;
          end
        end
        StLoad: begin
          if (abort_hit || rem_q == '0) begin
            state_q   <= StDone;
            done_q    <= 1'b1;
            done_id_q <= owner_q;
          end else begin
            state_q  <= StRun;
            enable_q <= 1'b1;
          end
        end
        StRun: begin
          rem_q <= rem_q - WIDTH'(1);
          if (abort_hit || rem_q == WIDTH'(1)) begin
            state_q   <= StDone;
            done_q    <= 1'b1;
            done_id_q <= owner_q;
          end else begin
            enable_q <= 1'b1;
          end
        end
        StDone: begin
          result_q <= cnt_value;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_smart_counter_ctrl.sv
// Self-checking bench for smart_counter_ctrl with an attached behavioural counter.
module tb_smart_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_start = '0, req0_steps = '0, req1_start = '0, req1_steps = '0;
  logic       cnt_load, cnt_enable, done, done_id;
  logic [7:0] cnt_data, result;
  logic [7:0] cnt_model = '0;
`ifdef SMART_COUNTER_CTRL_ABORT_EN
  logic       abort = 1'b0;
  logic       done_aborted;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int last_id  = 1;  // requester served last; 1 after reset gives req0 the tie

  typedef struct {
    logic       v0;
    logic       v1;
    logic [7:0] s0;
    logic [7:0] n0;
    logic [7:0] s1;
    logic [7:0] n1;
    int         exp_id;
    logic [7:0] exp_res;
  } vec_t;

  vec_t vecs[7];

  smart_counter_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_start(req0_start),
    .req0_steps(req0_steps),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_start(req1_start),
    .req1_steps(req1_steps),
    .cnt_load  (cnt_load),
    .cnt_enable(cnt_enable),
    .cnt_data  (cnt_data),
    .cnt_value (cnt_model),
    .done      (done),
    .done_id   (done_id),
    .result    (result)
`ifdef SMART_COUNTER_CTRL_ABORT_EN
    ,
    .abort       (abort),
    .done_aborted(done_aborted)
`endif
  );

  always #5 clk = ~clk;

  // External counter driven by the controller.
  always @(posedge clk) begin
    if (cnt_load) cnt_model <= cnt_data;
    else if (cnt_enable) cnt_model <= cnt_model + 8'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a negedge with the controller idle; returns the same way.
  task automatic run_cmd(input vec_t v, input bit scramble);
    int         sp;
    logic [7:0] st;
    sp = int'(v.exp_id == 1 ? v.n1 : v.n0);
    st = v.exp_id == 1 ? v.s1 : v.s0;
    req0_valid = v.v0; req0_start = v.s0; req0_steps = v.n0;
    req1_valid = v.v1; req1_start = v.s1; req1_steps = v.n1;
    #1;
    check("ready0_accept", req0_ready, v.exp_id == 0);
    check("ready1_accept", req1_ready, v.exp_id == 1);
    last_id = v.exp_id;
    for (int c = 1; c <= 2 + sp; c++) begin
      @(negedge clk);
      if (scramble) begin
        req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
        req0_start = 8'($urandom); req0_steps = 8'($urandom);
        req1_start = 8'($urandom); req1_steps = 8'($urandom);
      end
      #1;
      check("ready0_busy", req0_ready, 0);
      check("ready1_busy", req1_ready, 0);
      check("cnt_load", cnt_load, c == 1);
      check("cnt_enable", cnt_enable, c >= 2 && c <= 1 + sp);
      check("done", done, c == 2 + sp);
      if (c == 1) check("cnt_data", cnt_data, st);
      if (c == 2 + sp) begin
        check("result", result, v.exp_res);
        check("done_id", done_id, v.exp_id);
`ifdef SMART_COUNTER_CTRL_ABORT_EN
        check("done_aborted_normal", done_aborted, 0);
`endif
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("done_after", done, 0);
    check("result_hold", result, v.exp_res);
  endtask

  initial begin
    vec_t r;
    vecs[0] = '{1'b1, 1'b0, 8'h10, 8'd5, 8'h00, 8'd0, 0, 8'h15};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'd0, 8'hFE, 8'd4, 1, 8'h02};
    vecs[2] = '{1'b1, 1'b1, 8'h40, 8'd1, 8'h80, 8'd2, 0, 8'h41};
    vecs[3] = '{1'b1, 1'b1, 8'h40, 8'd1, 8'h80, 8'd2, 1, 8'h82};
    vecs[4] = '{1'b1, 1'b1, 8'h40, 8'd1, 8'h80, 8'd2, 0, 8'h41};
    vecs[5] = '{1'b1, 1'b1, 8'h40, 8'd1, 8'h80, 8'd2, 1, 8'h82};
    vecs[6] = '{1'b1, 1'b0, 8'h33, 8'd0, 8'h00, 8'd0, 0, 8'h33};

    // Reset state, with a valid request pending.
    req0_valid = 1'b1;
    #2;
    check("rst_ready0", req0_ready, 0);
    check("rst_load", cnt_load, 0);
    check("rst_enable", cnt_enable, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cnt_data", cnt_data, 0);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    foreach (vecs[i]) run_cmd(vecs[i], 1'b0);

    // Reset in the middle of a long run.
    req0_valid = 1'b1; req0_start = 8'h20; req0_steps = 8'd10;
    #1;
    check("rr_ready0", req0_ready, 1);
    repeat (4) @(negedge clk);
    check("rr_enable_before", cnt_enable, 1);
    rst_n = 1'b0;
    #1;
    check("rr_ready0_rst", req0_ready, 0);
    check("rr_load", cnt_load, 0);
    check("rr_enable", cnt_enable, 0);
    check("rr_done", done, 0);
    check("rr_cnt_data", cnt_data, 0);
    check("rr_result", result, 0);
    check("rr_done_id", done_id, 0);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rr_no_done", done, 0);
      check("rr_no_ready", req0_ready, 0);
    end
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_id = 1;
    #1;
    run_cmd(vecs[0], 1'b0);

`ifdef SMART_COUNTER_CTRL_ABORT_EN
    req0_valid = 1'b1; req0_start = 8'h00; req0_steps = 8'd10;
    #1;
    check("ab_ready0", req0_ready, 1);
    last_id = 0;
    repeat (4) @(negedge clk);
    req0_valid = 1'b0;
    abort = 1'b1;
    #1;
    check("ab_enable", cnt_enable, 0);
    check("ab_done_early", done, 0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("ab_done", done, 1);
    check("ab_result", result, 8'd2);
    check("ab_flag", done_aborted, 1);
    check("ab_done_id", done_id, 0);
    @(negedge clk);
    #1;
    check("ab_idle", done, 0);
`endif

    // Random commands against the arithmetic/round-robin model.
    for (int k = 0; k < 30; k++) begin
      r.v0 = 1'($urandom_range(0, 1));
      r.v1 = 1'($urandom_range(0, 1));
      if (!r.v0 && !r.v1) r.v0 = 1'b1;
      r.s0 = 8'($urandom); r.n0 = 8'($urandom_range(0, 12));
      r.s1 = 8'($urandom); r.n1 = 8'($urandom_range(0, 12));
      if (r.v0 && r.v1) r.exp_id = (last_id == 0) ? 1 : 0;
      else r.exp_id = r.v1 ? 1 : 0;
      r.exp_res = (r.exp_id == 1) ? 8'(r.s1 + r.n1) : 8'(r.s0 + r.n0);
      run_cmd(r, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
